// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register with hold, shift, rotate, parallel load and clear.
// Serial outputs are registered alongside q; qn and zero are derived from q.
module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             sout_r,
   output logic             sout_l,
   output logic             zero
);

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ROTR  = 3'b100;
   localparam logic [2:0] M_ROTL  = 3'b101;
   localparam logic [2:0] M_CLEAR = 3'b110;

   logic [WIDTH-1:0] r_q;
   logic             r_sout_r;
   logic             r_sout_l;
   logic [WIDTH-1:0] w_q_next;
   logic             w_sout_r_next;
   logic             w_sout_l_next;

   // Serial outputs keep their value unless the selected mode moves a bit out.
   always_comb begin
      w_q_next      = r_q;
      w_sout_r_next = r_sout_r;
      w_sout_l_next = r_sout_l;
      case (mode)
         M_HOLD: ;
         M_SHR: begin
            w_q_next      = {sin_r, r_q[WIDTH-1:1]};
            w_sout_r_next = r_q[0];
         end
         M_SHL: begin
            w_q_next      = {r_q[WIDTH-2:0], sin_l};
            w_sout_l_next = r_q[WIDTH-1];
         end
         M_LOAD: w_q_next = d;
         M_ROTR: begin
            w_q_next      = {r_q[0], r_q[WIDTH-1:1]};
            w_sout_r_next = r_q[0];
         end
         M_ROTL: begin
            w_q_next      = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_sout_l_next = r_q[WIDTH-1];
         end
         M_CLEAR: begin
            w_q_next      = '0;
            w_sout_r_next = 1'b0;
            w_sout_l_next = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q      <= RESET_VAL;
         r_sout_r <= 1'b0;
         r_sout_l <= 1'b0;
      end else if (en) begin
         r_q      <= w_q_next;
         r_sout_r <= w_sout_r_next;
         r_sout_l <= w_sout_l_next;
      end
   end

   assign q      = r_q;
   assign qn     = ~r_q;
   assign sout_r = r_sout_r;
   assign sout_l = r_sout_l;
   assign zero   = (r_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: fixed vector table, hand-written reset/rotate
// sequences and a randomised run against a behavioural reference model.
module tb_univ_shift_reg;

   localparam int         W    = 8;
   localparam logic [7:0] RVAL = 8'hA5;

   logic       clk, rst, en, sin_r, sin_l;
   logic [2:0] mode;
   logic [7:0] d;
   logic [7:0] q, qn;
   logic       sout_r, sout_l, zero;

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l), .q(q), .qn(qn),
      .sout_r(sout_r), .sout_l(sout_l), .zero(zero)
   );

   typedef struct packed {
      logic [7:0] q;
      logic       sr;
      logic       sl;
   } exp_t;

   typedef struct packed {
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       si_r;
      logic       si_l;
      exp_t       e;
   } vec_t;

   vec_t tbl[$];
   exp_t sb[$];
   exp_t st;
   int   n_vec  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   function automatic vec_t mk(logic e, logic [2:0] m, logic [7:0] dd,
                               logic sr_in, logic sl_in,
                               logic [7:0] eq, logic esr, logic esl);
      vec_t v;
      v.en = e; v.mode = m; v.d = dd; v.si_r = sr_in; v.si_l = sl_in;
      v.e.q = eq; v.e.sr = esr; v.e.sl = esl;
      return v;
   endfunction

   // Reference behaviour of one clock edge with rst low.
   function automatic exp_t model(exp_t s, logic e, logic [2:0] m,
                                  logic [7:0] dd, logic sr_in, logic sl_in);
      exp_t n;
      n = s;
      if (e) begin
         unique case (m)
            3'd1: begin n.q = (s.q >> 1) | {sr_in, 7'b0}; n.sr = s.q[0]; end
            3'd2: begin n.q = (s.q << 1) | {7'b0, sl_in}; n.sl = s.q[7]; end
            3'd3: n.q = dd;
            3'd4: begin n.q = (s.q >> 1) | (s.q << 7); n.sr = s.q[0]; end
            3'd5: begin n.q = (s.q << 1) | (s.q >> 7); n.sl = s.q[7]; end
            3'd6: begin n.q = 8'h00; n.sr = 1'b0; n.sl = 1'b0; end
            default: ;
         endcase
      end
      return n;
   endfunction

   task automatic chk(input string nm, input exp_t e);
      n_vec++;
      if (q !== e.q || qn !== ~e.q || sout_r !== e.sr || sout_l !== e.sl ||
          zero !== (e.q == 8'h00)) begin
         n_fail++;
         $display("FAIL %s: got q=%h qn=%h sr=%b sl=%b z=%b, want q=%h qn=%h sr=%b sl=%b z=%b",
                  nm, q, qn, sout_r, sout_l, zero,
                  e.q, ~e.q, e.sr, e.sl, (e.q == 8'h00));
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, check after the edge.
   task automatic apply(input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic sr_in, input logic sl_in,
                        input exp_t ex, input string nm);
      exp_t got;
      en = e; mode = m; d = dd; sin_r = sr_in; sin_l = sl_in;
      if (e && $isunknown(mode)) begin
         n_fail++;
         $display("FAIL mode_x: mode=%b with en=1, want a known value", mode);
      end
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk(nm, got);
   endtask

   task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic sr_in, input logic sl_in, input string nm);
      st = model(st, e, m, dd, sr_in, sl_in);
      apply(e, m, dd, sr_in, sl_in, st, nm);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;

      // load then shift right with sin_r=1
      tbl.push_back(mk(1, 3'd3, 8'h96, 0, 0, 8'h96, 0, 0));
      tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'hCB, 0, 0));
      tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'hE5, 1, 0));
      tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'hF2, 1, 0));
      // shift-left serialisation of 8'h81
      tbl.push_back(mk(1, 3'd3, 8'h81, 0, 0, 8'h81, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h02, 1, 1));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h04, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h08, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h10, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h20, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h40, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h80, 1, 0));
      tbl.push_back(mk(1, 3'd2, 8'h00, 0, 0, 8'h00, 1, 1));
      // rotate left with en toggling
      tbl.push_back(mk(1, 3'd3, 8'h01, 0, 0, 8'h01, 1, 1));
      tbl.push_back(mk(1, 3'd5, 8'h00, 0, 0, 8'h02, 1, 0));
      tbl.push_back(mk(0, 3'd5, 8'h00, 0, 0, 8'h02, 1, 0));
      tbl.push_back(mk(1, 3'd5, 8'h00, 0, 0, 8'h04, 1, 0));
      tbl.push_back(mk(0, 3'd5, 8'h00, 0, 0, 8'h04, 1, 0));
      tbl.push_back(mk(1, 3'd5, 8'h00, 0, 0, 8'h08, 1, 0));
      tbl.push_back(mk(0, 3'd5, 8'h00, 0, 0, 8'h08, 1, 0));
      tbl.push_back(mk(1, 3'd5, 8'h00, 0, 0, 8'h10, 1, 0));
      tbl.push_back(mk(0, 3'd5, 8'h00, 0, 0, 8'h10, 1, 0));
      // en=0 blocks a load; rotate right wraps LSB to MSB
      tbl.push_back(mk(0, 3'd3, 8'h55, 0, 0, 8'h10, 1, 0));
      tbl.push_back(mk(1, 3'd3, 8'h01, 0, 0, 8'h01, 1, 0));
      tbl.push_back(mk(1, 3'd4, 8'h00, 0, 0, 8'h80, 1, 0));
      // reserved mode holds, then clear
      tbl.push_back(mk(1, 3'd3, 8'hFF, 0, 0, 8'hFF, 1, 0));
      tbl.push_back(mk(1, 3'd7, 8'h00, 1, 1, 8'hFF, 1, 0));
      tbl.push_back(mk(1, 3'd6, 8'h00, 1, 1, 8'h00, 0, 0));
      // hold mode ignores d
      tbl.push_back(mk(1, 3'd3, 8'h3C, 0, 0, 8'h3C, 0, 0));
      tbl.push_back(mk(1, 3'd0, 8'hAA, 1, 1, 8'h3C, 0, 0));

      // reset is visible before any clock edge
      #2;
      chk("reset_async", '{q: RVAL, sr: 1'b0, sl: 1'b0});
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_held", '{q: RVAL, sr: 1'b0, sl: 1'b0});

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].si_r, tbl[i].si_l,
               tbl[i].e, $sformatf("tbl[%0d]", i));
      st = tbl[tbl.size()-1].e;

      // rotating right WIDTH times restores the start value
      step(1, 3'd3, 8'hB4, 0, 0, "rot8_load");
      for (int i = 0; i < W; i++) step(1, 3'd4, 8'h00, 0, 0, "rot8_step");
      n_vec++;
      if (q !== 8'hB4) begin
         n_fail++;
         $display("FAIL rot8_return: got q=%h, want q=b4", q);
      end

      // reset pulsed between edges in the middle of a shift-right stream
      step(1, 3'd1, 8'h00, 1, 0, "mid_shr1");
      step(1, 3'd1, 8'h00, 1, 0, "mid_shr2");
      sin_r = 1'b0;
      #2 rst = 1'b1;
      #1;
      st = '{q: RVAL, sr: 1'b0, sl: 1'b0};
      chk("mid_reset_async", st);
      #1 rst = 1'b0;
      step(1, 3'd1, 8'h00, 0, 0, "mid_after_release");

      // reset held across an edge dominates a pending load
      rst = 1'b1; en = 1'b1; mode = 3'd3; d = 8'h00;
      @(posedge clk); #1;
      st = '{q: RVAL, sr: 1'b0, sl: 1'b0};
      chk("reset_dominates", st);
      rst = 1'b0;

      // randomised mode mix, including mode change every cycle
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              8'($urandom), 1'($urandom), 1'($urandom), "random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
